// File: rtl/frame_tx_1101_if.sv
// Payload handshake between a word source and the 1101 frame transmitter.
interface frame_tx_1101_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/frame_tx_1101.sv
// Serial frame transmitter: sync 1101, then the payload MSB first with zero
// stuffing so that 1101 only ever appears at the frame start.
module frame_tx_1101 #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned GAP    = 2
) (
   input  logic            clk,
   input  logic            reset,
   frame_tx_1101_if.slave  s,
   output logic            y,
   output logic            busy
);

   localparam int unsigned CNT_W  = 5;
   localparam int unsigned GAP_W  = 4;
   localparam logic [3:0]  SYNC_PAT = 4'b1011;  // indexed by sync_cnt: 1,1,0,1

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_GAP
   } state_t;

   // Mirror of the downstream 1101 detector over the transmitted bits
   typedef enum logic [1:0] {
      SH_S0,
      SH_S1,
      SH_S11,
      SH_S110
   } shadow_t;

   state_t            state;
   shadow_t           shadow;
   logic [1:0]        sync_cnt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [DATA_W-1:0] sr;
   logic              ready_q;

   assign s.ready = ready_q;

   function automatic shadow_t shadow_next(input shadow_t cur, input logic b);
      shadow_t nxt;
      nxt = SH_S0;
      case (cur)
         SH_S0:   nxt = b ? SH_S1  : SH_S0;
         SH_S1:   nxt = b ? SH_S11 : SH_S0;
         SH_S11:  nxt = b ? SH_S11 : SH_S110;
         default: nxt = SH_S0;
      endcase
      return nxt;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         shadow   <= SH_S0;
         sync_cnt <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         sr       <= '0;
         y        <= 1'b0;
         ready_q  <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               y <= 1'b0;
               if (s.valid && ready_q) begin
                  sr       <= s.data;
                  y        <= SYNC_PAT[0];
                  sync_cnt <= 2'd1;
                  ready_q  <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_SYNC;
               end
            end

            ST_SYNC: begin
               y        <= SYNC_PAT[sync_cnt];
               sync_cnt <= sync_cnt + 2'd1;
               if (sync_cnt == 2'd3) begin
                  shadow  <= SH_S1;
                  bit_cnt <= '0;
                  state   <= ST_DATA;
               end
            end

            ST_DATA: begin
               // A pending "110" gets a stuffed 0 before the next payload bit
               if (shadow == SH_S110) begin
                  y      <= 1'b0;
                  shadow <= SH_S0;
               end else begin
                  y       <= sr[DATA_W-1];
                  sr      <= sr << 1;
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  shadow  <= shadow_next(shadow, sr[DATA_W-1]);
                  if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end
               end
            end

            ST_GAP: begin
               // Ready rises in time for an accept on the edge after the last gap zero
               y       <= 1'b0;
               gap_cnt <= gap_cnt + GAP_W'(1);
               if (gap_cnt == GAP_W'(GAP - 1)) begin
                  ready_q <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end
            end

            default: begin
               y       <= 1'b0;
               ready_q <= 1'b1;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_tx_1101.sv
// Directed bench for frame_tx_1101: frame contents, stuffing, handshake timing,
// back-to-back frames and asynchronous reset.
module tb_frame_tx_1101;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned GAP    = 2;

   logic clk = 1'b0;
   logic reset;
   logic y;
   logic busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc[$];

   frame_tx_1101_if #(.DATA_W(DATA_W)) bus ();

   frame_tx_1101 #(.DATA_W(DATA_W), .GAP(GAP)) dut (
      .clk   (clk),
      .reset (reset),
      .s     (bus.slave),
      .y     (y),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Record the cycle of every accepting edge
   always @(posedge clk) begin
      cyc++;
      if (reset && bus.valid && bus.ready) acc_cyc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One frame from IDLE; exp holds frame bits then GAP zeros, MSB first
   task automatic run_frame(input string tag, input logic [7:0] w,
                            input logic [31:0] exp, input int lf);
      int          n;
      int          nf;
      int          pos;
      logic [31:0] st;
      logic [3:0]  win;
      n   = lf + int'(GAP);
      nf  = 0;
      pos = -1;
      st  = '0;
      win = '0;
      bus.data  = w;
      bus.valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.valid = 1'b0;
            bus.data  = ~w;
            chk({tag, "_ready_after_accept"}, 32'(bus.ready), 32'd0);
            chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
         end
         st  = {st[30:0], y};
         win = {win[2:0], y};
         if (win == 4'b1101) begin
            nf++;
            if (pos < 0) pos = i;
         end
         if (i == n - 2) chk({tag, "_ready_low_last_gap"}, 32'(bus.ready), 32'd0);
         if (i == n - 1) begin
            chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
            chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
         end
      end
      chk({tag, "_stream"}, st, exp);
      chk({tag, "_det_count"}, 32'(nf), 32'd1);
      chk({tag, "_det_pos"}, 32'(pos), 32'd3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int          n0;
      int          nf;
      int          p0;
      int          p1;
      logic [31:0] st;
      logic [3:0]  win;

      bus.data  = '0;
      bus.valid = 1'b0;
      reset     = 1'b1;
      #1 reset  = 1'b0;
      #1;
      chk("reset_y", 32'(y), 32'd0);
      chk("reset_ready", 32'(bus.ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // First edge after release accepts
      run_frame("ff", 8'hFF, 32'h37FC, 12);
      run_frame("zero", 8'h00, 32'h3400, 12);
      run_frame("b4", 8'hB4, 32'hD990, 14);
      run_frame("6d", 8'h6D, 32'hD664, 14);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_y", 32'(y), 32'd0);
         chk("idle_ready", 32'(bus.ready), 32'd1);
      end

      // Back-to-back with valid held: B4 then FF
      n0  = acc_cyc.size();
      st  = '0;
      win = '0;
      nf  = 0;
      p0  = -1;
      p1  = -1;
      bus.data  = 8'hB4;
      bus.valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 0) bus.data = 8'hFF;
         if (i == 16) bus.valid = 1'b0;
         st  = {st[30:0], y};
         win = {win[2:0], y};
         if (win == 4'b1101) begin
            nf++;
            if (p0 < 0) p0 = i;
            else if (p1 < 0) p1 = i;
         end
      end
      chk("b2b_stream", st, {2'b00, 16'hD990, 14'h37FC});
      chk("b2b_det_count", 32'(nf), 32'd2);
      chk("b2b_det_first", 32'(p0), 32'd3);
      chk("b2b_det_second", 32'(p1), 32'd19);
      chk("b2b_accepts", 32'(acc_cyc.size() - n0), 32'd2);
      if (acc_cyc.size() - n0 == 2)
         chk("b2b_spacing", 32'(acc_cyc[n0 + 1] - acc_cyc[n0]), 32'd16);

      // Asynchronous reset in the middle of the B4 payload
      bus.data  = 8'hB4;
      bus.valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) bus.valid = 1'b0;
      end
      chk("mid_y_before_reset", 32'(y), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_reset_y", 32'(y), 32'd0);
      chk("mid_reset_ready", 32'(bus.ready), 32'd1);
      chk("mid_reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      run_frame("post_reset_b4", 8'hB4, 32'hD990, 14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
